// File: rtl/ti994a_key_scheduler_pkg.sv
// Shared types for the TI-99/4A key event scheduler.
package ti994a_key_scheduler_pkg;

    // One key event: {pressed, scan code}.
    localparam int unsigned KEY_EV_W = 9;

    typedef struct packed {
        logic       pressed;
        logic [7:0] code;
    } key_ev_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StHold  = 2'd2
    } ks_state_e;

endpackage

// File: rtl/ti994a_key_scheduler_fifo.sv
// Synchronous FIFO for live key events with registered full/empty flags.
module ti994a_key_scheduler_fifo
    import ti994a_key_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = KEY_EV_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // Storage array; no reset needed, contents are qualified by the flags.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, count and registered flags.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/ti994a_key_scheduler.sv
// Arbitrates live PS/2 and autotype key events into the keyboard matrix block,
// spacing issued events by a hold period so the console scan sees every state.
module ti994a_key_scheduler
    import ti994a_key_scheduler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned HOLD_CYCLES = 100000,
    parameter int unsigned HOLD_W      = 17
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_strobe,
    input  logic       ps2_pressed,
    input  logic [7:0] ps2_code,
    input  logic       at_valid,
    input  logic       at_pressed,
    input  logic [7:0] at_code,
    output logic       at_ready,
    input  logic       flush,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic [7:0] key_code,
    output logic       busy,
    output logic       ovf,
    input  logic       ovf_clr
);
    ks_state_e             state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [KEY_EV_W-1:0]   head_raw;
    key_ev_t               head_ev;
    key_ev_t               ps2_ev;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  drop;

    assign ps2_ev  = '{pressed: ps2_pressed, code: ps2_code};
    assign head_ev = key_ev_t'(head_raw);

    // Live events win: autotype is only offered when idle with nothing queued.
    assign pop        = (state == StIdle) && !fifo_empty && !flush;
    assign at_ready   = reset_n && (state == StIdle) && fifo_empty && !flush;
    assign key_strobe = (state == StIssue) && !flush;
    assign drop       = ps2_strobe && !flush && fifo_full && !pop;

    ti994a_key_scheduler_fifo #(
        .WIDTH (KEY_EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (ps2_strobe && !flush),
        .wdata   (ps2_ev),
        .pop     (pop),
        .rdata   (head_raw),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Event sequencer: IDLE -> ISSUE -> HOLD -> IDLE, flush aborts from anywhere.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            hold_cnt    <= '0;
            key_pressed <= 1'b0;
            key_code    <= '0;
        end else if (flush) begin
            state    <= StIdle;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        key_pressed <= head_ev.pressed;
                        key_code    <= head_ev.code;
                        state       <= StIssue;
                    end else if (at_valid) begin
                        key_pressed <= at_pressed;
                        key_code    <= at_code;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                    state    <= StHold;
                end
                StHold: begin
                    if (hold_cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Busy is a registered view of the previous cycle's activity.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state != StIdle) || !fifo_empty;
        end
    end

    // Sticky overflow flag; a drop in the clear cycle keeps it set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
